// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: opcodes, FSM state encoding
// and instruction field widths.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 11;
  localparam int INSTR_W_DEF = 16;
  localparam int OPC_W       = INSTR_W_DEF - ADDR_W_DEF;

  localparam logic [OPC_W-1:0] OP_RET  = 5'h1C;
  localparam logic [OPC_W-1:0] OP_JSR  = 5'h1D;
  localparam logic [OPC_W-1:0] OP_JMP  = 5'h1E;
  localparam logic [OPC_W-1:0] OP_HALT = 5'h1F;

  typedef enum logic [3:0] {
    BOOT_SETUP,
    BOOT_PULSE,
    FETCH,
    LATCH,
    DECODE,
    ISSUE,
    PULSE,
    SETTLE,
    HALTED
  } state_t;

  typedef struct packed {
    logic is_jmp;
    logic is_jsr;
    logic is_ret;
    logic is_halt;
    logic is_dp;
  } op_class_t;

endpackage

// File: rtl/fetch_sequencer_op_classify.sv
// Combinational opcode classifier: flags flow-control opcodes, everything
// else is a datapath instruction for the execute stage.
module op_classify
  import fetch_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output op_class_t        o_class
);

  always_comb begin
    o_class = '0;
    case (i_opcode)
      OP_JMP:  o_class.is_jmp  = 1'b1;
      OP_JSR:  o_class.is_jsr  = 1'b1;
      OP_RET:  o_class.is_ret  = 1'b1;
      OP_HALT: o_class.is_halt = 1'b1;
      default: o_class.is_dp   = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/sequencing stage: reads the ROM at the PC, decodes flow control and
// drives the PC strobes so every mode flag is set up a cycle before incr.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = ADDR_W_DEF,
  parameter int                INSTR_W      = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               pc_incr,
  output logic               pc_preload,
  output logic               pc_jsr,
  output logic               pc_ret,
  output logic [ADDR_W-1:0]  pc_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted
);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_incr;
  logic               r_preload;
  logic               r_jsr;
  logic               r_ret;
  logic [ADDR_W-1:0]  r_pc_addr;
  logic [INSTR_W-1:0] r_ir;
  logic               r_valid;
  logic               r_halted;

  logic [OPC_W-1:0]   w_opcode;
  logic [ADDR_W-1:0]  w_operand;
  op_class_t          w_class;

  // The ROM registers the address presented during LATCH, so its word is
  // visible in DECODE; decode straight from rom_data and capture it in IR.
  assign w_opcode  = rom_data[INSTR_W-1 -: OPC_W];
  assign w_operand = rom_data[ADDR_W-1:0];

  op_classify u_op_classify (
    .i_opcode (w_opcode),
    .o_class  (w_class)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= BOOT_SETUP;
      r_rom_addr <= '0;
      r_incr     <= 1'b0;
      r_preload  <= 1'b0;
      r_jsr      <= 1'b0;
      r_ret      <= 1'b0;
      r_pc_addr  <= RESET_VECTOR;
      r_ir       <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        BOOT_SETUP: begin
          r_preload <= 1'b1;
          r_pc_addr <= RESET_VECTOR;
          r_state   <= BOOT_PULSE;
        end
        BOOT_PULSE: begin
          r_incr  <= 1'b1;
          r_state <= SETTLE;
        end
        FETCH: begin
          r_rom_addr <= pc_in;
          r_state    <= LATCH;
        end
        LATCH: begin
          r_state <= DECODE;
        end
        DECODE: begin
          r_ir <= rom_data;
          if (w_class.is_jmp) begin
            r_preload <= 1'b1;
            r_pc_addr <= w_operand;
            r_state   <= PULSE;
          end else if (w_class.is_jsr) begin
            r_jsr     <= 1'b1;
            r_pc_addr <= w_operand;
            r_state   <= PULSE;
          end else if (w_class.is_ret) begin
            r_ret   <= 1'b1;
            r_state <= PULSE;
          end else if (w_class.is_halt) begin
            r_halted <= 1'b1;
            r_state  <= HALTED;
          end else begin
            r_valid <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
            r_state <= PULSE;
          end
        end
        PULSE: begin
          r_incr  <= 1'b1;
          r_state <= SETTLE;
        end
        // Flags drop together with incr, never ahead of it.
        SETTLE: begin
          r_incr    <= 1'b0;
          r_preload <= 1'b0;
          r_jsr     <= 1'b0;
          r_ret     <= 1'b0;
          r_state   <= FETCH;
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= BOOT_SETUP;
        end
      endcase
    end
  end

  assign rom_addr    = r_rom_addr;
  assign pc_incr     = r_incr;
  assign pc_preload  = r_preload;
  assign pc_jsr      = r_jsr;
  assign pc_ret      = r_ret;
  assign pc_addr     = r_pc_addr;
  assign instr_out   = r_ir;
  assign instr_valid = r_valid;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small ROM and PC model that
// reacts to the sequencer's strobes the way the real PC does.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [10:0] romA;
    logic [10:0] pcA;
    logic        incr;
    logic        pre;
    logic        jsr;
    logic        ret;
    logic        valid;
    logic        halted;
    logic [15:0] instr;
  } outs_t;

  typedef struct {
    logic  rst;
    logic  rdy;
    outs_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] pc_in;
  logic [10:0] rom_addr;
  logic [15:0] rom_data;
  logic        pc_incr, pc_preload, pc_jsr, pc_ret;
  logic [10:0] pc_addr;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        halted;

  int testsRun = 0;
  int testsFailed = 0;
  int xfers = 0;
  logic monOn = 1'b0;

  logic [15:0] rom [0:2047];
  logic [10:0] pcReg = 11'h7AB;
  logic [10:0] retAddr = '0;
  logic [2:0]  prevFlags = '0;

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pc_incr     (pc_incr),
    .pc_preload  (pc_preload),
    .pc_jsr      (pc_jsr),
    .pc_ret      (pc_ret),
    .pc_addr     (pc_addr),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: one-cycle read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // PC model: acts on the rising edge of incr using the mode flags.
  always @(posedge pc_incr) begin
    if (pc_preload) pcReg <= pc_addr;
    else if (pc_jsr) begin
      retAddr <= pcReg + 11'd1;
      pcReg   <= pcReg + {1'b0, pc_addr[9:0]};
    end else if (pc_ret) pcReg <= retAddr;
    else pcReg <= pcReg + 11'd1;
  end
  assign pc_in = pcReg;

  always @(posedge clk) if (!reset && instr_valid && instr_ready) xfers++;

  // Flag invariants: at most one mode flag, and flags never change while incr is high.
  always @(negedge clk) begin
    if (monOn) begin
      testsRun++;
      if (!$onehot0({pc_preload, pc_jsr, pc_ret})) begin
        testsFailed++;
        $display("[TB] FAIL flag_onehot: flags=%b required at most one set", {pc_preload, pc_jsr, pc_ret});
      end
      if (pc_incr) begin
        testsRun++;
        if ({pc_preload, pc_jsr, pc_ret} !== prevFlags) begin
          testsFailed++;
          $display("[TB] FAIL flag_setup: flags=%b during incr, required %b from cycle before", {pc_preload, pc_jsr, pc_ret}, prevFlags);
        end
      end
    end
    prevFlags = {pc_preload, pc_jsr, pc_ret};
  end

  function automatic outs_t mk(input logic [10:0] ra, input logic [10:0] pa,
                               input logic inc, input logic pre, input logic js,
                               input logic rt, input logic val, input logic hlt,
                               input logic [15:0] ins);
    outs_t o;
    o = {ra, pa, inc, pre, js, rt, val, hlt, ins};
    return o;
  endfunction

  function automatic vec_t mkVec(input logic rst, input logic rdy, input outs_t e);
    vec_t v;
    v.rst = rst;
    v.rdy = rdy;
    v.exp = e;
    return v;
  endfunction

  task automatic applyStimulus(input logic rst, input logic rdy);
    reset       = rst;
    instr_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    outs_t req;
    act = {rom_addr, pc_addr, pc_incr, pc_preload, pc_jsr, pc_ret, instr_valid, halted, instr_out};
    req = exp;
    if (!exp.valid) begin
      act.instr = '0;
      req.instr = '0;
    end
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got romA=%h pcA=%h incr=%b pre=%b jsr=%b ret=%b valid=%b halted=%b instr=%h, required romA=%h pcA=%h incr=%b pre=%b jsr=%b ret=%b valid=%b halted=%b instr=%h",
               name, act.romA, act.pcA, act.incr, act.pre, act.jsr, act.ret, act.valid, act.halted, act.instr,
               req.romA, req.pcA, req.incr, req.pre, req.jsr, req.ret, req.valid, req.halted, req.instr);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int req);
    testsRun++;
    if (act != req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t vecs[$];
    int n;

    for (int a = 0; a < 2048; a++) rom[a] = 16'h0000;
    rom[11'h000] = 16'hF005;
    rom[11'h005] = 16'h1234;
    rom[11'h006] = 16'h2ABC;
    rom[11'h007] = 16'hF123;
    rom[11'h123] = 16'hE810;
    rom[11'h133] = 16'hE000;
    rom[11'h124] = 16'hF800;

    // Reset, boot, JMP 5, then datapath op 16'h1234 accepted immediately.
    vecs.push_back(mkVec(1, 1, mk(11'h000, 11'h000, 0, 0, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(1, 1, mk(11'h000, 11'h000, 0, 0, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h000, 11'h000, 0, 1, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h000, 11'h000, 1, 1, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h000, 11'h000, 0, 0, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h000, 11'h000, 0, 0, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h000, 11'h000, 0, 0, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h000, 11'h005, 0, 1, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h000, 11'h005, 1, 1, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h000, 11'h005, 0, 0, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h005, 11'h005, 0, 0, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h005, 11'h005, 0, 0, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h005, 11'h005, 0, 0, 0, 0, 1, 0, 16'h1234)));
    vecs.push_back(mkVec(0, 1, mk(11'h005, 11'h005, 0, 0, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h005, 11'h005, 1, 0, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h005, 11'h005, 0, 0, 0, 0, 0, 0, 16'h0)));
    vecs.push_back(mkVec(0, 1, mk(11'h006, 11'h005, 0, 0, 0, 0, 0, 0, 16'h0)));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].rdy);
      monOn = 1'b1;
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end
    checkCount("dp_single_xfer", xfers, 1);

    // Backpressure: ready low for 4 cycles in ISSUE.
    applyStimulus(0, 0); checkOutput("bp_decode", mk(11'h006, 11'h005, 0, 0, 0, 0, 0, 0, 16'h0));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0);
      checkOutput($sformatf("bp_hold%0d", i), mk(11'h006, 11'h005, 0, 0, 0, 0, 1, 0, 16'h2ABC));
    end
    applyStimulus(0, 1); checkOutput("bp_xfer", mk(11'h006, 11'h005, 0, 0, 0, 0, 0, 0, 16'h0));
    checkCount("bp_single_xfer", xfers, 2);
    applyStimulus(0, 0); checkOutput("bp_incr", mk(11'h006, 11'h005, 1, 0, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 0); checkOutput("bp_settle", mk(11'h006, 11'h005, 0, 0, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 0); checkOutput("bp_fetch7", mk(11'h007, 11'h005, 0, 0, 0, 0, 0, 0, 16'h0));

    // JMP 0x123.
    applyStimulus(0, 1); checkOutput("jmp_decode", mk(11'h007, 11'h005, 0, 0, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 1); checkOutput("jmp_flag", mk(11'h007, 11'h123, 0, 1, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 1); checkOutput("jmp_incr", mk(11'h007, 11'h123, 1, 1, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 1); checkOutput("jmp_settle", mk(11'h007, 11'h123, 0, 0, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 1); checkOutput("jmp_fetch", mk(11'h123, 11'h123, 0, 0, 0, 0, 0, 0, 16'h0));

    // JSR +0x010, then RET.
    applyStimulus(0, 1); checkOutput("jsr_decode", mk(11'h123, 11'h123, 0, 0, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 1); checkOutput("jsr_flag", mk(11'h123, 11'h010, 0, 0, 1, 0, 0, 0, 16'h0));
    applyStimulus(0, 1); checkOutput("jsr_incr", mk(11'h123, 11'h010, 1, 0, 1, 0, 0, 0, 16'h0));
    applyStimulus(0, 1); checkOutput("jsr_settle", mk(11'h123, 11'h010, 0, 0, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 1); checkOutput("jsr_fetch", mk(11'h133, 11'h010, 0, 0, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 1); checkOutput("ret_decode", mk(11'h133, 11'h010, 0, 0, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 1); checkOutput("ret_flag", mk(11'h133, 11'h010, 0, 0, 0, 1, 0, 0, 16'h0));
    applyStimulus(0, 1); checkOutput("ret_incr", mk(11'h133, 11'h010, 1, 0, 0, 1, 0, 0, 16'h0));
    applyStimulus(0, 1); checkOutput("ret_settle", mk(11'h133, 11'h010, 0, 0, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 1); checkOutput("ret_fetch", mk(11'h124, 11'h010, 0, 0, 0, 0, 0, 0, 16'h0));

    // HALT: no further strobes for 20 cycles.
    applyStimulus(0, 1); checkOutput("halt_decode", mk(11'h124, 11'h010, 0, 0, 0, 0, 0, 0, 16'h0));
    for (int i = 0; i < 21; i++) begin
      applyStimulus(0, 1);
      checkOutput($sformatf("halted%0d", i), mk(11'h124, 11'h010, 0, 0, 0, 0, 0, 1, 16'h0));
    end

    // Reboot, then reset while an instruction waits in ISSUE.
    applyStimulus(1, 0); checkOutput("reboot_reset", mk(11'h000, 11'h000, 0, 0, 0, 0, 0, 0, 16'h0));
    n = 0;
    do begin
      applyStimulus(0, 0);
      n++;
    end while (!instr_valid && n < 40);
    checkOutput("midop_issue", mk(11'h005, 11'h005, 0, 0, 0, 0, 1, 0, 16'h1234));
    applyStimulus(0, 0); checkOutput("midop_hold", mk(11'h005, 11'h005, 0, 0, 0, 0, 1, 0, 16'h1234));
    applyStimulus(1, 1); checkOutput("midop_reset", mk(11'h000, 11'h000, 0, 0, 0, 0, 0, 0, 16'h0));
    checkCount("midop_no_xfer", xfers, 2);
    applyStimulus(0, 0); checkOutput("midop_boot_pre", mk(11'h000, 11'h000, 0, 1, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 0); checkOutput("midop_boot_incr", mk(11'h000, 11'h000, 1, 1, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 0); checkOutput("midop_boot_settle", mk(11'h000, 11'h000, 0, 0, 0, 0, 0, 0, 16'h0));
    applyStimulus(0, 0); checkOutput("midop_boot_fetch", mk(11'h000, 11'h000, 0, 0, 0, 0, 0, 0, 16'h0));
    checkCount("midop_pc_reloaded", int'(pc_in), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
